// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID register and a RUN/HALT_PEND/HALTED halt sequencer.
// Optional macro FETCH_PERF_CNT_EN adds a saturating 16-bit fetch_count output.
module fetch_stage #(
   parameter int                    DATA_WIDTH    = 20,
   parameter int                    ADDRESS_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] HALT_WORD     = 20'hFFFFF,
   parameter int                    DRAIN_CYCLES  = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     Stall,
   input  logic                     Flush,
   input  logic                     branch_taken,
   input  logic [ADDRESS_WIDTH-1:0] branch_target,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0]    imem_data,
   output logic [DATA_WIDTH-1:0]    instruction,
   output logic [ADDRESS_WIDTH-1:0] pc_result,
   output logic                     valid,
   output logic                     halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]              fetch_count
`endif
);

   localparam int CNT_W = $clog2(DRAIN_CYCLES + 1) + 1;
   localparam logic [CNT_W-1:0] DRAIN_LIM = CNT_W'(DRAIN_CYCLES);

   typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;

   state_t                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0]    instr_q, instr_d;
   logic [ADDRESS_WIDTH-1:0] pcr_q, pcr_d;
   logic                     valid_q, valid_d;
   logic                     halted_q, halted_d;
   logic [CNT_W-1:0]         drain_q, drain_d;
   logic [CNT_W-1:0]         drain_inc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= RUN;
         pc_q     <= '0;
         instr_q  <= '0;
         pcr_q    <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         drain_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pcr_q    <= pcr_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
         drain_q  <= drain_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      pcr_d     = pcr_q;
      valid_d   = valid_q;
      halted_d  = halted_q;
      drain_d   = drain_q;
      drain_inc = drain_q + 1'b1;
      unique case (state_q)
         RUN: begin
            if (branch_taken) begin
               pc_d    = branch_target;
               instr_d = '0;
               valid_d = 1'b0;
            end else if (Flush) begin
               instr_d = '0;
               valid_d = 1'b0;
            end else if (!Stall) begin
               instr_d = imem_data;
               pcr_d   = pc_q;
               valid_d = 1'b1;
               // Halt word is latched but PC parks on it so nothing past it is fetched.
               if (imem_data == HALT_WORD) begin
                  state_d = HALT_PEND;
                  drain_d = '0;
               end else begin
                  pc_d = pc_q + 1'b1;
               end
            end
         end
         HALT_PEND: begin
            if (branch_taken) begin
               pc_d    = branch_target;
               instr_d = '0;
               valid_d = 1'b0;
               drain_d = '0;
               state_d = RUN;
            end else begin
               // Flush outranks Stall for IF/ID, but the drain count only advances unstalled.
               if (Flush || !Stall) begin
                  instr_d = '0;
                  valid_d = 1'b0;
               end
               if (!Stall) begin
                  drain_d = drain_inc;
                  if (drain_inc >= DRAIN_LIM) begin
                     state_d  = HALTED;
                     halted_d = 1'b1;
                  end
               end
            end
         end
         HALTED: begin
         end
         default: state_d = RUN;
      endcase
   end

   assign imem_addr   = pc_q;
   assign instruction = instr_q;
   assign pc_result   = pcr_q;
   assign valid       = valid_q;
   assign halted      = halted_q;

`ifdef FETCH_PERF_CNT_EN
   logic        advance;
   logic [15:0] fetch_cnt_q, fetch_cnt_d;

   assign advance = (state_q == RUN) && !branch_taken && !Flush && !Stall;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      if (advance && (fetch_cnt_q != 16'hFFFF)) begin
         fetch_cnt_d = fetch_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign fetch_count = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios then random hazards/resets against a
// cycle-level reference model of the fetch rules.
module tb_fetch_stage;

   localparam logic [19:0] HALT = 20'hFFFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        Stall, Flush, branch_taken;
   logic [7:0]  branch_target;
   logic [7:0]  imem_addr;
   logic [19:0] imem_data;
   logic [19:0] instruction;
   logic [7:0]  pc_result;
   logic        valid, halted;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_count;
`endif

   logic [19:0] mem [256];
   assign imem_data = mem[imem_addr];

   fetch_stage #(.DATA_WIDTH(20), .ADDRESS_WIDTH(8), .HALT_WORD(20'hFFFFF), .DRAIN_CYCLES(3)) dut (
      .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .instruction(instruction), .pc_result(pc_result),
      .valid(valid), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
      , .fetch_count(fetch_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] instr;
      logic [7:0]  pcr;
      logic        valid;
      logic        halted;
      logic [7:0]  addr;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];
   int n_checks = 0;
   int n_errors = 0;

   // Reference model: mode 0 = fetching, 1 = draining after halt word, 2 = stopped.
   logic [7:0]  m_pc, m_pcr;
   logic [19:0] m_instr;
   logic        m_valid, m_halted;
   int          m_mode, m_left;
   int          m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 8'h00; m_pcr = 8'h00; m_instr = 20'h0;
      m_valid = 1'b0; m_halted = 1'b0; m_mode = 0; m_left = 0; m_cnt = 0;
   endtask

   task automatic model_step(input logic r, input logic b, input logic [7:0] t,
                             input logic f, input logic s);
      logic [19:0] w;
      if (!r) begin
         model_reset();
      end else if (m_mode == 0) begin
         if (b) begin
            m_pc = t; m_instr = 20'h0; m_valid = 1'b0;
         end else if (f) begin
            m_instr = 20'h0; m_valid = 1'b0;
         end else if (!s) begin
            w = mem[m_pc];
            m_instr = w; m_pcr = m_pc; m_valid = 1'b1;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (w == HALT) begin
               m_mode = 1; m_left = 3;
            end else begin
               m_pc = m_pc + 8'd1;
            end
         end
      end else if (m_mode == 1) begin
         if (b) begin
            m_pc = t; m_instr = 20'h0; m_valid = 1'b0; m_mode = 0;
         end else begin
            if (f || !s) begin
               m_instr = 20'h0; m_valid = 1'b0;
            end
            if (!s) begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  m_mode = 2; m_halted = 1'b1;
               end
            end
         end
      end
   endtask

   // One clock: drive at negedge, predict, queue expectation, return shortly after the edge.
   task automatic cyc(input logic r, input logic b, input logic [7:0] t,
                      input logic f, input logic s);
      exp_t e;
      @(negedge clk);
      rst = r; branch_taken = b; branch_target = t; Flush = f; Stall = s;
      model_step(r, b, t, f, s);
      e.instr = m_instr; e.pcr = m_pcr; e.valid = m_valid; e.halted = m_halted;
      e.addr = m_pc; e.cnt = 16'(m_cnt);
      q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("instruction", 32'(instruction), 32'(e.instr));
            chk("pc_result", 32'(pc_result), 32'(e.pcr));
            chk("valid", 32'(valid), 32'(e.valid));
            chk("halted", 32'(halted), 32'(e.halted));
            chk("imem_addr", 32'(imem_addr), 32'(e.addr));
`ifdef FETCH_PERF_CNT_EN
            chk("fetch_count", 32'(fetch_count), 32'(e.cnt));
`endif
         end
      end
   end

   initial begin : driver
      logic [19:0] w;
      rst = 1'b0; Stall = 1'b0; Flush = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
      model_reset();
      for (int i = 0; i < 256; i++) begin
         w = 20'($urandom);
         mem[i] = (w == HALT) ? 20'h0 : w;
      end
      for (int i = 0; i < 4; i++) mem[i] = 20'(i + 1);
      mem[6] = HALT;

      cyc(0, 0, 8'h00, 0, 0);
      cyc(0, 0, 8'h00, 0, 0);
      chk("reset_valid", 32'(valid), 32'd0);
      chk("reset_addr", 32'(imem_addr), 32'd0);

      // Sequential fetch from address 0.
      for (int i = 0; i < 4; i++) cyc(1, 0, 8'h00, 0, 0);
      chk("seq_instr", 32'(instruction), 32'h4);
      chk("seq_pcr", 32'(pc_result), 32'h3);
`ifdef FETCH_PERF_CNT_EN
      chk("seq_fetch_count", 32'(fetch_count), 32'd4);
`endif

      // Stall twice at PC=5, then flush, then refetch 5.
      cyc(1, 0, 8'h00, 0, 0);
      cyc(1, 0, 8'h00, 0, 1);
      cyc(1, 0, 8'h00, 0, 1);
      chk("stall_addr", 32'(imem_addr), 32'h5);
      chk("stall_pcr", 32'(pc_result), 32'h4);
      cyc(1, 0, 8'h00, 1, 0);
      chk("flush_valid", 32'(valid), 32'd0);
      cyc(1, 0, 8'h00, 0, 0);
      chk("refetch_pcr", 32'(pc_result), 32'h5);

      // Branch beats Stall and Flush.
      cyc(1, 1, 8'h40, 1, 1);
      chk("branch_addr", 32'(imem_addr), 32'h40);
      chk("branch_valid", 32'(valid), 32'd0);
      cyc(1, 0, 8'h00, 0, 0);
      chk("branch_fetch_pcr", 32'(pc_result), 32'h40);

      // PC wrap.
      cyc(1, 1, 8'hFF, 0, 0);
      cyc(1, 0, 8'h00, 0, 0);
      chk("wrap_pcr", 32'(pc_result), 32'hFF);
      chk("wrap_addr", 32'(imem_addr), 32'h00);

      // Halt at address 6; one stalled cycle does not count toward the drain.
      cyc(1, 1, 8'h06, 0, 0);
      cyc(1, 0, 8'h00, 0, 0);
      chk("halt_word_latched", 32'(instruction), 32'(HALT));
      cyc(1, 0, 8'h00, 0, 1);
      cyc(1, 0, 8'h00, 0, 0);
      cyc(1, 0, 8'h00, 1, 0);
      chk("halt_pending", 32'(halted), 32'd0);
      cyc(1, 0, 8'h00, 0, 0);
      chk("halt_reached", 32'(halted), 32'd1);
      chk("halt_addr", 32'(imem_addr), 32'h06);
      for (int i = 0; i < 3; i++) cyc(1, 1, 8'($urandom), 1'($urandom), 1'($urandom));

      // Asynchronous reset in the middle of a cycle while halted.
      #5;
      rst = 1'b0;
      #1;
      chk("async_rst_instr", 32'(instruction), 32'd0);
      chk("async_rst_pcr", 32'(pc_result), 32'd0);
      chk("async_rst_valid", 32'(valid), 32'd0);
      chk("async_rst_halted", 32'(halted), 32'd0);
      chk("async_rst_addr", 32'(imem_addr), 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("async_rst_count", 32'(fetch_count), 32'd0);
`endif
      model_reset();
      cyc(0, 0, 8'h00, 0, 0);
      cyc(1, 0, 8'h00, 0, 0);
      chk("restart_instr", 32'(instruction), 32'h1);
      chk("restart_pcr", 32'(pc_result), 32'h0);

      // Branch during HALT_PEND resumes fetching.
      mem[8'h20] = HALT;
      cyc(1, 1, 8'h20, 0, 0);
      cyc(1, 0, 8'h00, 0, 0);
      cyc(1, 0, 8'h00, 0, 0);
      cyc(1, 1, 8'h10, 0, 0);
      cyc(1, 0, 8'h00, 0, 0);
      chk("resume_pcr", 32'(pc_result), 32'h10);
      chk("resume_valid", 32'(valid), 32'd1);
      for (int i = 0; i < 4; i++) cyc(1, 0, 8'h00, 0, 0);
      chk("resume_not_halted", 32'(halted), 32'd0);

      // Randomized hazards, branches, halts and resets.
      for (int i = 0; i < 256; i++) begin
         w = 20'($urandom);
         if (w == HALT) w = 20'h0;
         mem[i] = ($urandom_range(15) == 0) ? HALT : w;
      end
      for (int i = 0; i < 1500; i++) begin
         cyc(($urandom_range(60) != 0), ($urandom_range(9) == 0), 8'($urandom),
             ($urandom_range(7) == 0), ($urandom_range(4) == 0));
      end

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
